// File: rtl/mips_bus_pkg.sv
// Shared types and defaults for the MIPS unified-bus sequencer.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        COMMIT = 2'd2,
        HALT   = 2'd3
    } bus_state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    // States in which a bus access is outstanding and the watchdog runs
    function automatic logic is_bus_state(input bus_state_t s);
        return (s == FETCH) || (s == DATA);
    endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Counts consecutive stalled bus cycles and flags the one that reaches TIMEOUT.
module mips_bus_watchdog
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic count,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_count <= '0;
        end else if (clear) begin
            wait_count <= '0;
        end else if (count) begin
            wait_count <= wait_count + CW'(1);
        end
    end

    // Fires on the stalled cycle whose edge would bring the count to TIMEOUT
    assign expire = count && (wait_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mips_cpu_bus_sequencer.sv
// Sequences a Harvard MIPS core onto one wait-request bus, stepping the core via cpu_clk_enable.
module mips_cpu_bus_sequencer
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    output logic        cpu_clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        bus_error
);

    bus_state_t state;
    bus_state_t state_next;
    logic       error_set;
    logic       write_access;
    logic       watchdog_count;
    logic       watchdog_expire;

    assign watchdog_count = is_bus_state(state) && mem_waitrequest;

    mips_bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .count  (watchdog_count),
        .clear  (!watchdog_count),
        .expire (watchdog_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FETCH;
            write_access   <= 1'b0;
            bus_error      <= 1'b0;
            instr_readdata <= '0;
            data_readdata  <= '0;
        end else begin
            state <= state_next;
            if (error_set) begin
                bus_error <= 1'b1;
            end
            if (state == FETCH && !mem_waitrequest) begin
                instr_readdata <= mem_readdata;
                write_access   <= data_write;
            end
            if (state == DATA && !mem_waitrequest && !write_access) begin
                data_readdata <= mem_readdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        error_set  = 1'b0;
        case (state)
            FETCH: begin
                if (watchdog_expire) begin
                    state_next = HALT;
                    error_set  = 1'b1;
                end else if (!mem_waitrequest) begin
                    // A core asking to read and write at once is malformed
                    if (data_read && data_write) begin
                        state_next = HALT;
                        error_set  = 1'b1;
                    end else if (data_read || data_write) begin
                        state_next = DATA;
                    end else begin
                        state_next = COMMIT;
                    end
                end
            end
            DATA: begin
                if (watchdog_expire) begin
                    state_next = HALT;
                    error_set  = 1'b1;
                end else if (!mem_waitrequest) begin
                    state_next = COMMIT;
                end
            end
            COMMIT:  state_next = cpu_active ? FETCH : HALT;
            HALT:    state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    // Strobes and the core enable are gated by reset so they drop the instant it asserts
    always_comb begin
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        cpu_clk_enable = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_read       = 1'b1;
                    mem_address    = instr_address;
                    mem_byteenable = 4'b1111;
                end
                DATA: begin
                    mem_address = data_address;
                    if (write_access) begin
                        mem_write      = 1'b1;
                        mem_byteenable = data_byteenable;
                        mem_writedata  = data_writedata;
                    end else begin
                        mem_read       = 1'b1;
                        mem_byteenable = 4'b1111;
                    end
                end
                COMMIT:  cpu_clk_enable = 1'b1;
                default: cpu_clk_enable = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_sequencer.sv
// Directed self-checking bench for mips_cpu_bus_sequencer (watchdog shortened to 4 cycles).
module tb_mips_cpu_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_active;
    logic        cpu_clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_byteenable;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        bus_error;

    int compared = 0;
    int mismatched = 0;
    int strobe_cycles = 0;
    int pulse_cycles = 0;
    int write_cycles = 0;
    int overlap_cycles = 0;
    int s0;
    int p0;
    int w0;

    mips_cpu_bus_sequencer #(
        .TIMEOUT(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_active      (cpu_active),
        .cpu_clk_enable  (cpu_clk_enable),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_byteenable (data_byteenable),
        .data_writedata  (data_writedata),
        .data_readdata   (data_readdata),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest),
        .bus_error       (bus_error)
    );

    always #5 clk = ~clk;

    // Tally bus activity once per cycle, away from the active edge
    always @(negedge clk) begin
        if (mem_read || mem_write) strobe_cycles++;
        if (cpu_clk_enable) pulse_cycles++;
        if (mem_write) write_cycles++;
        if (mem_read && mem_write) overlap_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ia, input logic rd, input logic wr,
                                 input logic [31:0] da, input logic [3:0] be, input logic [31:0] wd,
                                 input logic [31:0] rdata, input logic wait_req, input logic active);
        instr_address   = ia;
        data_read       = rd;
        data_write      = wr;
        data_address    = da;
        data_byteenable = be;
        data_writedata  = wd;
        mem_readdata    = rdata;
        mem_waitrequest = wait_req;
        cpu_active      = active;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetAndRelease();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "[TB] bench timed out");
    end

    initial begin
        applyStimulus(32'hBFC00000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h00000023, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("reset_read", mem_read, 1'b0);
        checkOutput("reset_write", mem_write, 1'b0);
        checkOutput("reset_enable", cpu_clk_enable, 1'b0);
        checkOutput("reset_error", bus_error, 1'b0);
        checkOutput("reset_instr", instr_readdata, 32'h0);
        checkOutput("reset_data", data_readdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Instruction-only step: fetch in cycle 1, commit pulse in cycle 2
        checkOutput("fetch_addr", mem_address, 32'hBFC00000);
        checkOutput("fetch_read", mem_read, 1'b1);
        checkOutput("fetch_be", mem_byteenable, 4'hF);
        checkOutput("fetch_no_pulse", cpu_clk_enable, 1'b0);
        nextCycle();
        checkOutput("first_instr", instr_readdata, 32'h00000023);
        checkOutput("first_pulse", cpu_clk_enable, 1'b1);
        checkOutput("commit_no_read", mem_read, 1'b0);

        // Load with two wait cycles: fetch, 3 data cycles, commit on the 5th
        nextCycle();
        applyStimulus(32'hBFC00004, 1'b1, 1'b0, 32'h00001000, 4'hF, 32'h0, 32'h00000001, 1'b0, 1'b1);
        checkOutput("load_fetch_addr", mem_address, 32'hBFC00004);
        nextCycle();
        applyStimulus(32'hBFC00004, 1'b1, 1'b0, 32'h00001000, 4'hF, 32'h0, 32'hBAD0BAD0, 1'b1, 1'b1);
        checkOutput("load_addr", mem_address, 32'h00001000);
        checkOutput("load_read", mem_read, 1'b1);
        checkOutput("load_no_write", mem_write, 1'b0);
        nextCycle();
        checkOutput("load_hold_addr", mem_address, 32'h00001000);
        checkOutput("load_wait_no_pulse", cpu_clk_enable, 1'b0);
        nextCycle();
        applyStimulus(32'hBFC00004, 1'b1, 1'b0, 32'h00001000, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        checkOutput("load_not_yet", data_readdata, 32'h0);
        checkOutput("load_last_wait_no_pulse", cpu_clk_enable, 1'b0);
        nextCycle();
        checkOutput("load_data", data_readdata, 32'hDEADBEEF);
        checkOutput("load_pulse", cpu_clk_enable, 1'b1);
        checkOutput("load_instr", instr_readdata, 32'h00000001);

        // Store: one write cycle with the core's lanes and data
        nextCycle();
        applyStimulus(32'hBFC00008, 1'b0, 1'b1, 32'h00002000, 4'b0011, 32'h12345678, 32'h00000002, 1'b0, 1'b1);
        w0 = write_cycles;
        nextCycle();
        checkOutput("store_write", mem_write, 1'b1);
        checkOutput("store_no_read", mem_read, 1'b0);
        checkOutput("store_addr", mem_address, 32'h00002000);
        checkOutput("store_be", mem_byteenable, 4'b0011);
        checkOutput("store_wdata", mem_writedata, 32'h12345678);
        nextCycle();
        checkOutput("store_one_write", write_cycles - w0, 1);
        checkOutput("store_keeps_load_data", data_readdata, 32'hDEADBEEF);
        checkOutput("store_pulse", cpu_clk_enable, 1'b1);

        // Core halts: last commit pulse, then silence on the bus
        nextCycle();
        applyStimulus(32'hBFC0000C, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h00000003, 1'b0, 1'b0);
        nextCycle();
        checkOutput("halt_commit_pulse", cpu_clk_enable, 1'b1);
        nextCycle();
        s0 = strobe_cycles;
        p0 = pulse_cycles;
        checkOutput("halt_no_read", mem_read, 1'b0);
        for (int i = 0; i < 6; i++) begin
            mem_waitrequest = i[0];
            nextCycle();
        end
        checkOutput("halt_no_strobes", strobe_cycles - s0, 0);
        checkOutput("halt_no_pulses", pulse_cycles - p0, 0);

        // Read and write requested together
        applyStimulus(32'hBFC00000, 1'b1, 1'b1, 32'h00004000, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
        resetAndRelease();
        nextCycle();
        checkOutput("conflict_error", bus_error, 1'b1);
        checkOutput("conflict_no_strobe", mem_read | mem_write, 1'b0);
        s0 = strobe_cycles;
        repeat (4) nextCycle();
        checkOutput("conflict_no_access", strobe_cycles - s0, 0);
        reset = 1'b1;
        #1;
        checkOutput("reset_clears_error", bus_error, 1'b0);

        // Reset during a stalled write
        applyStimulus(32'hBFC00010, 1'b0, 1'b1, 32'h00003000, 4'hF, 32'hAAAA5555, 32'h0, 1'b0, 1'b1);
        resetAndRelease();
        nextCycle();
        applyStimulus(32'hBFC00010, 1'b0, 1'b1, 32'h00003000, 4'hF, 32'hAAAA5555, 32'h0, 1'b1, 1'b1);
        checkOutput("pre_reset_write", mem_write, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("reset_drops_write", mem_write, 1'b0);
        checkOutput("reset_no_pulse", cpu_clk_enable, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        applyStimulus(32'hBFC00020, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        checkOutput("restart_fetch_read", mem_read, 1'b1);
        checkOutput("restart_fetch_addr", mem_address, 32'hBFC00020);
        checkOutput("restart_no_write", mem_write, 1'b0);

        // Fetch stalled forever: watchdog trips after 4 stalled cycles
        applyStimulus(32'hBFC00030, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        resetAndRelease();
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("timeout_pending_%0d", i), bus_error, 1'b0);
            checkOutput($sformatf("timeout_read_%0d", i), mem_read, 1'b1);
            nextCycle();
        end
        checkOutput("timeout_error", bus_error, 1'b1);
        checkOutput("timeout_read_dropped", mem_read, 1'b0);
        s0 = strobe_cycles;
        p0 = pulse_cycles;
        mem_waitrequest = 1'b0;
        repeat (5) nextCycle();
        checkOutput("timeout_stays_halted", strobe_cycles - s0, 0);
        checkOutput("timeout_no_pulses", pulse_cycles - p0, 0);
        checkOutput("timeout_error_sticky", bus_error, 1'b1);

        checkOutput("never_both_strobes", overlap_cycles, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
